// File: rtl/hazard_sb.sv
// Register scoreboard for an in-order decode stage: tracks in-flight producers per
// architectural register and derives RAW/WAW/structural stalls plus operand bypass selects.

module hazard_sb_ent #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set,
  input  logic [CW-1:0] i_lat,
  input  logic [1:0]    i_cls,
  output logic [CW-1:0] o_cnt,
  output logic [1:0]    o_cls,
  output logic          o_wbp,
  output logic          o_pend
);
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cls;
  logic          r_wbp;
  logic          r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_cls  <= '0;
      r_wbp  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      // pending next cycle exactly when an issue lands or the countdown is still running
      r_pend <= i_set | (r_cnt != '0);
      if (i_set) begin
        r_cnt <= i_lat;
        r_cls <= i_cls;
        r_wbp <= 1'b0;
      end else if (r_cnt > CW'(1)) begin
        r_cnt <= r_cnt - CW'(1);
      end else if (r_cnt == CW'(1)) begin
        r_cnt <= '0;
        r_wbp <= 1'b1;
      end else begin
        r_wbp <= 1'b0;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_cls  = r_cls;
  assign o_wbp  = r_wbp;
  assign o_pend = r_pend;
endmodule

module hazard_sb #(
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int EXT_LAT  = 4,
  parameter int EXT_PIPE = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_vld,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_dst,
  input  logic [1:0]        issue_cls,
  input  logic              flush,
  input  logic [NRD-1:0]    rd_re,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic              stall,
  output logic [NRD*3-1:0]  byp_sel,
  output logic [NREG-1:0]   pend_mask
);
  localparam int CW = 4;

  function automatic logic [CW-1:0] lat_of(input logic [1:0] c);
    case (c)
      2'd0:    lat_of = CW'(1);
      2'd2:    lat_of = CW'(EXT_LAT);
      default: lat_of = CW'(2);
    endcase
  endfunction

  logic [NREG-1:0][CW-1:0] w_cnt;
  logic [NREG-1:0][1:0]    w_cls;
  logic [NREG-1:0]         w_wbp;
  logic [NREG-1:0]         w_pend;
  logic [NRD-1:0]          w_raw;
  logic [CW-1:0]           w_lat;
  logic                    w_acc, w_waw, w_str;

  assign w_lat = lat_of(issue_cls);
  assign w_acc = issue_vld & ~stall & ~flush;

  // r0 is hardwired and never tracked
  assign w_cnt[0]  = '0;
  assign w_cls[0]  = '0;
  assign w_wbp[0]  = 1'b0;
  assign w_pend[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hazard_sb_ent #(.CW(CW)) u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_set  (w_acc & issue_we & (issue_dst == AW'(r))),
      .i_lat  (w_lat),
      .i_cls  (issue_cls),
      .o_cnt  (w_cnt[r]),
      .o_cls  (w_cls[r]),
      .o_wbp  (w_wbp[r]),
      .o_pend (w_pend[r])
    );
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [CW-1:0] w_rc;
    logic [2:0]    w_byp;

    assign w_ra     = rd_addr[k*AW +: AW];
    assign w_rc     = w_cnt[w_ra];
    assign w_raw[k] = rd_re[k] && (w_ra != '0) && (w_rc > CW'(1));

    // POP shares the load return path, so it reports the LOAD source
    always_comb begin
      w_byp = 3'd0;
      if (w_ra != '0) begin
        if (w_rc == CW'(1))
          w_byp = (w_cls[w_ra] == 2'd3) ? 3'd2 : (3'({1'b0, w_cls[w_ra]}) + 3'd1);
        else if ((w_rc == '0) && w_wbp[w_ra])
          w_byp = 3'd4;
      end
    end
    assign byp_sel[k*3 +: 3] = w_byp;
  end

  assign w_waw = issue_we && (issue_dst != '0) && (w_cnt[issue_dst] > w_lat);

  if (EXT_PIPE == 0) begin : g_busy
    logic [CW-1:0] r_ext_busy;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_ext_busy <= '0;
      else if (w_acc && (issue_cls == 2'd2))  r_ext_busy <= CW'(EXT_LAT);
      else if (r_ext_busy != '0)              r_ext_busy <= r_ext_busy - CW'(1);
    end
    assign w_str = (issue_cls == 2'd2) && (r_ext_busy > CW'(1));
  end else begin : g_nobusy
    assign w_str = 1'b0;
  end

  assign stall     = issue_vld & ((|w_raw) | w_waw | w_str);
  assign pend_mask = w_pend;
endmodule
